sevenseg_capture: RTL and testbench
===================================

# sevenseg_capture

Receive-side counterpart of the seven-segment decoder. The block samples a multiplexed seven-segment display bus (digit selects plus segment lines) and reconstructs the displayed digit values as BCD. It qualifies each pattern for stability, decodes it back to a nibble, and flags illegal patterns. It sits on the test/loopback path, so the display driver's output can be checked against the values the driver was asked to show.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit positions.
- STABLE_CYCLES, 4, consecutive identical samples (≥1) required before a pattern is committed.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- an_in  input  NUM_DIGITS  digit select, active-high, one-hot when a digit is driven; bit i = digit i.
- seg_in  input  7  segment lines, active-high, bit6=a … bit0=g (same encoding as the decoder).
- digits  output  4*NUM_DIGITS  decoded values; digit i at [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set when digit i holds a legally decoded value.
- update  output  1  one-cycle pulse when a commit changes any digit value or valid bit.
- err  output  1  one-cycle pulse on a committed illegal pattern or multi-hot an_in.
- frame_done  output  1  one-cycle pulse when every digit position has committed since the last pulse.

## Operation
- Input stage: {an_in, seg_in} registered into r every cycle; previous r kept for comparison.
- Stability counter cnt (width clog2(STABLE_CYCLES)+1): cleared when r changes, else increments, saturating at STABLE_CYCLES-1.
- FSM states: IDLE, TRACK, HELD.
  - IDLE: r.an == 0 (inter-digit blanking). Stays in IDLE, no commit. Goes to TRACK when r.an != 0.
  - TRACK: commits when cnt == STABLE_CYCLES-1, then goes to HELD. Goes to IDLE if r.an becomes 0. Any change of r restarts cnt and stays in TRACK.
  - HELD: at most one commit per stable pattern. Any change of r goes to TRACK, or to IDLE if the new an is 0.
- Commit with r.an one-hot at position i:
  - Legal patterns decode as the inverse of the decoder table: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9. Result: digits[i] = value, digit_valid[i] = 1.
  - 0000000 (blank): digits[i] = 4'hF, digit_valid[i] = 0, no err.
  - Any other pattern: err pulse, digit_valid[i] = 0, digits[i] unchanged.
- Commit with r.an multi-hot: err pulse only; no digit is changed. This still counts as a commit for the FSM (goes to HELD).
- update pulses only if digits[i] or digit_valid[i] actually changed.
- Seen-mask (NUM_DIGITS bits): bit i is set on every one-hot commit to digit i. When the mask becomes all-ones, frame_done pulses and the mask clears in the same cycle. A commit landing on that same edge is recorded in the fresh mask.

## Timing
- Reset values: digits all 4'hF, digit_valid 0, update 0, err 0, frame_done 0, FSM IDLE, cnt 0, r 0, seen-mask 0.
- Reset is asynchronous and clears all state immediately, including mid-qualification; a partially qualified pattern is discarded.
- Latency:
  - A pattern is first registered at edge k and held at the inputs through edge k+STABLE_CYCLES-1.
  - It commits at edge k+STABLE_CYCLES: digits, digit_valid, update, err and frame_done become visible after that edge.
  - With STABLE_CYCLES=1, commit occurs at edge k+1.
- A change at edge k+STABLE_CYCLES-1 or earlier prevents the commit; the new pattern restarts qualification.
- update, err and frame_done are high for exactly one cycle per event. update and frame_done may coincide, and err and frame_done may coincide.
- The same pattern held indefinitely produces exactly one commit.

## Test plan
- Reset: assert reset with random inputs → digits=16'hFFFF, digit_valid=0, all pulses 0; assert reset mid-qualification → no commit after release until a full STABLE_CYCLES hold.
- Basic commit: an_in=0001, seg_in=1111001 held 4 cycles → after edge k+4, digits[3:0]=3, digit_valid[0]=1, single update pulse; holding 20 more cycles gives no further pulses.
- Glitch rejection: an_in=0010, seg_in=0110011 held 3 cycles, then seg_in=1011011 held 4 → digits[7:4]=5 only, one update pulse, the value 4 never appears.
- Illegal/blank: an_in=0100, seg_in=1000000 → err pulse, digit_valid[2]=0, digits[11:8] unchanged; then seg_in=0000000 → digits[11:8]=F, no err.
- Full scan: drive 3,2,0,2 on digits 0..3 with an_in=0000 gaps → digits=16'h2023, digit_valid=4'hF, frame_done on the 4th commit; repeat identical scan → frame_done again, no update pulses.
- Select faults: an_in=0011 held 4 cycles → err pulse, digits unchanged; an_in=0000 with any seg_in → no commit, no err.

Source files
------------

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: samples a multiplexed seven-segment bus, qualifies each
// {an, seg} pattern for stability and rebuilds the displayed digits as BCD.
//
// state | meaning
// IDLE  | registered digit select is zero (inter-digit blanking), nothing to qualify
// TRACK | non-blank select registered, counting stable cycles toward a commit
// HELD  | current pattern already committed, waiting for it to change
module sevenseg_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   an_in,
   input  logic [6:0]              seg_in,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update,
   output logic                    err,
   output logic                    frame_done
);

   localparam int CW = $clog2(STABLE_CYCLES) + 1;
   localparam int RW = NUM_DIGITS + 7;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

   state_t                  state_q, state_d;
   logic [RW-1:0]           r_q, r_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic                    update_q, update_d;
   logic                    err_q, err_d;
   logic                    frame_q, frame_d;

   logic                    r_chg;
   logic                    commit;
   logic                    one_hot;
   logic [NUM_DIGITS-1:0]   an_r;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [6:0]              seg_r;
   logic [4:0]              dec;
   logic [NUM_DIGITS-1:0]   seen_next;

   // Inverse of the decoder table; returns {legal, value}.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'b1111110: seg_decode = {1'b1, 4'd0};
         7'b0110000: seg_decode = {1'b1, 4'd1};
         7'b1101101: seg_decode = {1'b1, 4'd2};
         7'b1111001: seg_decode = {1'b1, 4'd3};
         7'b0110011: seg_decode = {1'b1, 4'd4};
         7'b1011011: seg_decode = {1'b1, 4'd5};
         7'b1011111: seg_decode = {1'b1, 4'd6};
         7'b1110000: seg_decode = {1'b1, 4'd7};
         7'b1111111: seg_decode = {1'b1, 4'd8};
         7'b1111011: seg_decode = {1'b1, 4'd9};
         default:    seg_decode = 5'b0;
      endcase
   endfunction

   // Input capture, stability counting and FSM next-state selection.
   // Change detection compares the incoming sample against r so the counter
   // restarts on the same edge that registers a new pattern.
   always_comb begin
      r_d     = {an_in, seg_in};
      r_chg   = (r_d != r_q);
      an_next = r_d[RW-1:7];
      an_r    = r_q[RW-1:7];
      seg_r   = r_q[6:0];
      one_hot = (an_r != '0) && ((an_r & (an_r - NUM_DIGITS'(1))) == '0);
      dec     = seg_decode(seg_r);
      commit  = (state_q == TRACK) && (cnt_q == CNT_MAX);

      if (r_chg)
         cnt_d = '0;
      else if (cnt_q == CNT_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CW'(1);

      state_d = state_q;
      case (state_q)
         IDLE:    if (an_next != '0) state_d = TRACK;
         TRACK:   if (r_chg) state_d = (an_next == '0) ? IDLE : TRACK;
                  else if (cnt_q == CNT_MAX) state_d = HELD;
         HELD:    if (r_chg) state_d = (an_next == '0) ? IDLE : TRACK;
         default: state_d = IDLE;
      endcase
   end

   // Commit action: decode into the selected digit and form the event pulses.
   always_comb begin
      digits_d  = digits_q;
      valid_d   = valid_q;
      seen_d    = seen_q;
      seen_next = seen_q;
      update_d  = 1'b0;
      err_d     = 1'b0;
      frame_d   = 1'b0;
      if (commit) begin
         if (!one_hot) begin
            err_d = 1'b1;
         end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (an_r[i]) begin
                  if (dec[4]) begin
                     digits_d[4*i +: 4] = dec[3:0];
                     valid_d[i]         = 1'b1;
                  end else if (seg_r == 7'b0) begin
                     digits_d[4*i +: 4] = 4'hF;
                     valid_d[i]         = 1'b0;
                  end else begin
                     valid_d[i] = 1'b0;
                     err_d      = 1'b1;
                  end
               end
            end
            update_d  = (digits_d != digits_q) || (valid_d != valid_q);
            seen_next = seen_q | an_r;
            if (&seen_next) begin
               frame_d = 1'b1;
               seen_d  = '0;
            end else begin
               seen_d = seen_next;
            end
         end
      end
   end

   // All state and registered outputs; reset discards any partial qualification.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         r_q      <= '0;
         cnt_q    <= '0;
         digits_q <= '1;
         valid_q  <= '0;
         seen_q   <= '0;
         update_q <= 1'b0;
         err_q    <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         seen_q   <= seen_d;
         update_q <= update_d;
         err_q    <= err_d;
         frame_q  <= frame_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign update      = update_q;
   assign err         = err_q;
   assign frame_done  = frame_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scenarios plus random bus traffic,
// compared every cycle against a pattern-age reference model.
`timescale 1ns/1ps
module tb_sevenseg_capture;

   localparam int ND = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [ND-1:0] an_in = '0;
   logic [6:0]    seg_in = '0;
   logic [15:0]   digits;
   logic [ND-1:0] digit_valid;
   logic          update, err, frame_done;

   sevenseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .reset       (reset),
      .an_in       (an_in),
      .seg_in      (seg_in),
      .digits      (digits),
      .digit_valid (digit_valid),
      .update      (update),
      .err         (err),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011};

   // reference model: the registered pattern, the edge it was registered on,
   // whether it has already committed, and the visible digit state
   logic [10:0]   m_r;
   int            edge_n = 0;
   int            m_reg_edge;
   bit            m_done;
   logic [3:0]    m_dig [ND];
   logic [ND-1:0] m_val;
   logic [ND-1:0] m_seen;
   bit            e_upd, e_err, e_fd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_r        = '0;
      m_reg_edge = edge_n;
      m_done     = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
      m_val  = '0;
      m_seen = '0;
      e_upd  = 0;
      e_err  = 0;
      e_fd   = 0;
   endtask

   task automatic model_commit(input logic [10:0] p);
      logic [3:0] a;
      logic [6:0] s;
      int idx, v;
      logic [3:0] nd;
      bit nv;
      a = p[10:7];
      s = p[6:0];
      if ($countones(a) != 1) begin
         e_err = 1;
         return;
      end
      idx = 0;
      for (int i = 0; i < ND; i++) if (a[i]) idx = i;
      v = -1;
      for (int k = 0; k < 10; k++) if (pat[k] == s) v = k;
      if (v >= 0) begin
         nd = 4'(v); nv = 1;
      end else if (s == 7'b0) begin
         nd = 4'hF; nv = 0;
      end else begin
         nd = m_dig[idx]; nv = 0; e_err = 1;
      end
      e_upd = (nd != m_dig[idx]) || (nv != m_val[idx]);
      m_dig[idx] = nd;
      m_val[idx] = nv;
      m_seen[idx] = 1'b1;
      if (m_seen == '1) begin
         e_fd = 1;
         m_seen = '0;
      end
   endtask

   // a registered pattern with a non-zero select commits exactly SC edges
   // after it was registered, once
   task automatic model_edge(input logic [10:0] inp);
      e_upd = 0; e_err = 0; e_fd = 0;
      edge_n++;
      if (!m_done && m_r[10:7] != '0 && (edge_n - m_reg_edge) == SC) begin
         model_commit(m_r);
         m_done = 1;
      end
      if (inp != m_r) begin
         m_r        = inp;
         m_reg_edge = edge_n;
         m_done     = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [15:0] exp_d;
      for (int i = 0; i < ND; i++) exp_d[4*i +: 4] = m_dig[i];
      check({tag, ".digits"}, 32'(digits), 32'(exp_d));
      check({tag, ".valid"}, 32'(digit_valid), 32'(m_val));
      check({tag, ".update"}, 32'(update), 32'(e_upd));
      check({tag, ".err"}, 32'(err), 32'(e_err));
      check({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
   endtask

   task automatic step(input logic [3:0] a, input logic [6:0] s);
      @(negedge clk);
      an_in  = a;
      seg_in = s;
      model_edge({a, s});
      @(posedge clk);
      #1;
      check_outputs("cyc");
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      repeat (n) step(a, s);
   endtask

   // asynchronous reset a little after a rising edge, inputs held at (a, s)
   // throughout, then one modelled edge after release
   task automatic do_reset(input logic [3:0] a, input logic [6:0] s, input int cyc);
      #2;
      an_in  = a;
      seg_in = s;
      reset  = 1'b1;
      #1;
      model_reset();
      check_outputs("rst");
      repeat (cyc) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_edge({a, s});
      @(posedge clk);
      #1;
      check_outputs("rel");
   endtask

   function automatic logic [3:0] rand_an();
      int sel;
      logic [3:0] a;
      sel = $urandom_range(0, 99);
      if (sel < 30) return 4'b0;
      if (sel < 85) return 4'(1 << $urandom_range(0, ND - 1));
      do a = 4'($urandom); while ($countones(a) < 2);
      return a;
   endfunction

   function automatic logic [6:0] rand_seg();
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 70) return pat[$urandom_range(0, 9)];
      if (sel < 80) return 7'b0;
      return 7'($urandom);
   endfunction

   initial begin
      model_reset();
      @(posedge clk);
      do_reset(4'($urandom), 7'($urandom), 2);
      hold(4'b0000, 7'b0, 2);

      // basic commit, then a long hold with no further events
      hold(4'b0001, 7'b1111001, 24);
      hold(4'b0000, 7'b0, 2);

      // glitch rejection: 4 held too briefly, 5 commits
      hold(4'b0010, 7'b0110011, 3);
      hold(4'b0010, 7'b1011011, 4);
      hold(4'b0010, 7'b1011011, 3);
      hold(4'b0000, 7'b0, 2);

      // illegal pattern then blank on digit 2
      hold(4'b0100, 7'b1000000, 5);
      hold(4'b0100, 7'b0000000, 5);
      hold(4'b0000, 7'b0, 2);

      // full scan 3,2,0,2 twice from a clean mask
      do_reset(4'b0, 7'b0, 1);
      for (int rep = 0; rep < 2; rep++) begin
         hold(4'b0001, pat[3], 5); hold(4'b0000, 7'b0, 2);
         hold(4'b0010, pat[2], 5); hold(4'b0000, 7'b0, 2);
         hold(4'b0100, pat[0], 5); hold(4'b0000, 7'b0, 2);
         hold(4'b1000, pat[2], 5); hold(4'b0000, 7'b0, 2);
      end

      // select faults
      hold(4'b0011, pat[5], 6);
      hold(4'b0000, 7'($urandom), 6);

      // reset in the middle of qualification
      hold(4'b0001, pat[7], 2);
      do_reset(4'b0001, pat[7], 2);
      hold(4'b0001, pat[7], 6);
      hold(4'b0000, 7'b0, 2);

      // random bus traffic with hold lengths straddling the qualification window
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0)
            do_reset(rand_an(), rand_seg(), $urandom_range(0, 2));
         else
            hold(rand_an(), rand_seg(), $urandom_range(1, SC + 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
